// File: rtl/fifo_txuart.sv
// Byte-FIFO-draining 8N1 serial transmitter with 1 or 2 stop bits.
// Optional CTS flow control is compiled in with `define FIFOTX_CTS_EN.
module fifo_txuart #(
  parameter int CLOCKS_PER_BAUD = 868,
  parameter int NSTOP           = 1
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_empty_n,
  input  logic [7:0] i_data,
`ifdef FIFOTX_CTS_EN
  input  logic       i_cts_n,
`endif
  output logic       o_rd,
  output logic       o_uart_tx,
  output logic       o_busy,
  output logic [1:0] dbg_state
);

  // FIFO read handshake: a byte is consumed on every cycle where o_rd is high.
  // The FIFO must present its head byte on i_data whenever i_empty_n is high,
  // and o_rd is only raised while i_empty_n is high, so no stall path exists.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  localparam logic [23:0] BAUD_RELOAD = 24'(CLOCKS_PER_BAUD - 1);
  localparam logic        STOP_LAST   = 1'(NSTOP - 1);

  state_t      state;
  state_t      state_nxt;
  logic [23:0] baud_cnt;
  logic [2:0]  bit_idx;
  logic        stop_cnt;
  logic [7:0]  shift;
  logic        baud_done;
  logic        last_stop;
  logic        ready;
  logic        cts_ok;
  logic        pop;

`ifdef FIFOTX_CTS_EN
  logic cts_meta;
  logic cts_sync;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cts_meta <= 1'b0;
      cts_sync <= 1'b0;
    end else begin
      cts_meta <= ~i_cts_n;
      cts_sync <= cts_meta;
    end
  end

  assign cts_ok = cts_sync;
`else
  assign cts_ok = 1'b1;
`endif

  assign baud_done = (baud_cnt == 24'd0);
  assign last_stop = (stop_cnt == STOP_LAST);

  // Ready in the very last stop-bit cycle lets the next frame start with no gap.
  assign ready = (state == S_IDLE) ||
                 ((state == S_STOP) && baud_done && last_stop);

  // Reset only gates the strobe itself; the registers are already held by it.
  assign pop  = ready && i_empty_n && cts_ok;
  assign o_rd = pop && !i_reset;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (pop) state_nxt = S_START;
      end
      S_START: begin
        if (baud_done) state_nxt = S_DATA;
      end
      S_DATA: begin
        if (baud_done && (bit_idx == 3'd7)) state_nxt = S_STOP;
      end
      S_STOP: begin
        if (baud_done && last_stop) state_nxt = pop ? S_START : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    o_uart_tx = 1'b1;
    o_busy    = 1'b1;
    case (state)
      S_IDLE: begin
        o_uart_tx = 1'b1;
        o_busy    = 1'b0;
      end
      S_START: o_uart_tx = 1'b0;
      S_DATA:  o_uart_tx = shift[0];
      S_STOP:  o_uart_tx = 1'b1;
      default: begin
        o_uart_tx = 1'b1;
        o_busy    = 1'b0;
      end
    endcase
  end

  assign dbg_state = state;

  // A pop takes priority in every state: it only happens in IDLE or the last stop cycle.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      baud_cnt <= 24'd0;
      bit_idx  <= 3'd0;
      stop_cnt <= 1'b0;
      shift    <= 8'd0;
    end else if (pop) begin
      shift    <= i_data;
      baud_cnt <= BAUD_RELOAD;
      bit_idx  <= 3'd0;
      stop_cnt <= 1'b0;
    end else begin
      case (state)
        S_START: begin
          if (baud_done) begin
            baud_cnt <= BAUD_RELOAD;
            bit_idx  <= 3'd0;
          end else begin
            baud_cnt <= baud_cnt - 24'd1;
          end
        end
        S_DATA: begin
          if (baud_done) begin
            baud_cnt <= BAUD_RELOAD;
            shift    <= {1'b0, shift[7:1]};
            bit_idx  <= bit_idx + 3'd1;
            stop_cnt <= 1'b0;
          end else begin
            baud_cnt <= baud_cnt - 24'd1;
          end
        end
        S_STOP: begin
          if (baud_done) begin
            if (!last_stop) begin
              stop_cnt <= stop_cnt + 1'b1;
              baud_cnt <= BAUD_RELOAD;
            end
          end else begin
            baud_cnt <= baud_cnt - 24'd1;
          end
        end
        default: begin
          baud_cnt <= 24'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_txuart.sv
// Bench for fifo_txuart: a queue-backed FIFO model feeds the DUT, popped bytes go
// to an expected queue, and a cycle-exact line receiver decodes frames against it.
module tb_fifo_txuart;

  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst;
  logic       empty_n;
  logic [7:0] data;
  logic       rd;
  logic       tx;
  logic       busy;
  logic [1:0] dbg_state;

  logic       empty_n2;
  logic [7:0] data2;
  logic       rd2;
  logic       tx2;
  logic       busy2;
  logic [1:0] dbg_state2;

`ifdef FIFOTX_CTS_EN
  logic       cts_n;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  int         rd_cyc_q[$];
  int         start_cyc_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fifo_txuart #(.CLOCKS_PER_BAUD(CPB), .NSTOP(1)) u_dut (
    .i_clk(clk),
    .i_reset(rst),
    .i_empty_n(empty_n),
    .i_data(data),
`ifdef FIFOTX_CTS_EN
    .i_cts_n(cts_n),
`endif
    .o_rd(rd),
    .o_uart_tx(tx),
    .o_busy(busy),
    .dbg_state(dbg_state)
  );

  fifo_txuart #(.CLOCKS_PER_BAUD(CPB), .NSTOP(2)) u_dut2 (
    .i_clk(clk),
    .i_reset(rst),
    .i_empty_n(empty_n2),
    .i_data(data2),
`ifdef FIFOTX_CTS_EN
    .i_cts_n(cts_n),
`endif
    .o_rd(rd2),
    .o_uart_tx(tx2),
    .o_busy(busy2),
    .dbg_state(dbg_state2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic fifo_drive();
    empty_n = (fifo_q.size() != 0);
    data    = empty_n ? fifo_q[0] : 8'h00;
  endtask

  task automatic push_byte(input logic [7:0] b);
    fifo_q.push_back(b);
    fifo_drive();
  endtask

  task automatic sync();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle(input int limit, input bit need_empty, output int busy_n);
    int n;
    n = 0;
    busy_n = 0;
    do begin
      @(negedge clk);
      if (busy) busy_n++;
      n++;
    end while ((busy || (need_empty && empty_n)) && n < limit);
    check("wait_idle_bound", 32'(n < limit), 32'd1);
  endtask

  // FIFO side: record each pop as an expected byte, then retire the head after the edge.
  initial begin
    logic       prev_rd;
    logic       rd_now;
    logic [7:0] tmp;
    prev_rd = 1'b0;
    forever begin
      @(negedge clk);
      rd_now = rd;
      if (rd_now) begin
        check("rd_needs_data", 32'(empty_n), 32'd1);
        check("rd_not_back_to_back", 32'(prev_rd), 32'd0);
        exp_q.push_back(data);
        rd_cyc_q.push_back(cyc);
      end
      prev_rd = rd_now;
      if (rd_now) begin
        @(posedge clk);
        #1;
        if (fifo_q.size() != 0) tmp = fifo_q.pop_front();
        fifo_drive();
      end
    end
  end

  // Line receiver: every cycle of a frame must carry the level implied by the byte.
  initial begin
    logic [7:0] exp_b;
    logic [7:0] got;
    logic       exp_line;
    int         nbad;
    int         bitpos;
    bit         aborted;
    forever begin
      @(negedge clk);
      if (rst !== 1'b0 || tx !== 1'b0) continue;
      start_cyc_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("frame_was_expected", 32'd0, 32'd1);
        exp_b = 8'h00;
      end else begin
        exp_b = exp_q.pop_front();
      end
      nbad    = 0;
      aborted = 1'b0;
      got     = 8'h00;
      for (int k = 0; k < FRAME; k++) begin
        if (k > 0) @(negedge clk);
        if (rst !== 1'b0) begin
          aborted = 1'b1;
          break;
        end
        bitpos = k / CPB;
        if (bitpos == 0)      exp_line = 1'b0;
        else if (bitpos <= 8) exp_line = exp_b[bitpos-1];
        else                  exp_line = 1'b1;
        if (tx !== exp_line || busy !== 1'b1) nbad++;
        if ((k % CPB) == (CPB / 2) && bitpos >= 1 && bitpos <= 8) got[bitpos-1] = tx;
      end
      if (!aborted) begin
        check("frame_byte", 32'(got), 32'(exp_b));
        check("frame_shape_errors", 32'(nbad), 32'd0);
      end
    end
  end

  task automatic run_nstop2(input logic [7:0] b);
    logic       ln[64];
    logic       bz[64];
    int         n;
    int         busy_n;
    int         stop_n;
    int         low_n;
    int         extra_rd;
    logic [7:0] got;
    sync();
    data2    = b;
    empty_n2 = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (rd2 !== 1'b1 && n < 20);
    check("nstop2_pop", 32'(rd2), 32'd1);
    @(posedge clk);
    #2 empty_n2 = 1'b0;
    extra_rd = 0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      ln[k] = tx2;
      bz[k] = busy2;
      if (rd2) extra_rd++;
    end
    busy_n = 0;
    stop_n = 0;
    low_n  = 0;
    got    = 8'h00;
    for (int k = 0; k < 64; k++) begin
      if (bz[k]) busy_n++;
      if (k < CPB && ln[k] == 1'b0) low_n++;
      if (k >= 9 * CPB && ln[k] && bz[k]) stop_n++;
    end
    for (int i = 0; i < 8; i++) got[i] = ln[CPB * (i + 1) + CPB / 2];
    check("nstop2_busy_cycles", 32'(busy_n), 32'(11 * CPB));
    check("nstop2_stop_cycles", 32'(stop_n), 32'(2 * CPB));
    check("nstop2_start_low", 32'(low_n), 32'(CPB));
    check("nstop2_byte", 32'(got), 32'(b));
    check("nstop2_extra_pop", 32'(extra_rd), 32'd0);
  endtask

  initial begin
    #5000000;
    bad++;
    $display("FAIL global_timeout actual=running required=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    int n;
    int n0;
    int busy_n;
    int bad_tx;
    int bad_rd;
    int bad_busy;
    int nb;

    rst      = 1'b1;
    empty_n  = 1'b0;
    data     = 8'h00;
    empty_n2 = 1'b0;
    data2    = 8'h00;
`ifdef FIFOTX_CTS_EN
    cts_n    = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("reset_tx", 32'(tx), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_rd", 32'(rd), 32'd0);
    sync();
    rst = 1'b0;

    // Empty FIFO: line must stay idle.
    bad_tx = 0;
    bad_rd = 0;
    bad_busy = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) bad_tx++;
      if (rd !== 1'b0) bad_rd++;
      if (busy !== 1'b0) bad_busy++;
    end
    check("empty_tx_cycles_low", 32'(bad_tx), 32'd0);
    check("empty_rd_cycles", 32'(bad_rd), 32'd0);
    check("empty_busy_cycles", 32'(bad_busy), 32'd0);

    // Single byte frame.
    n0 = rd_cyc_q.size();
    sync();
    push_byte(8'h55);
    wait_idle(400, 1'b1, busy_n);
    check("single_busy_cycles", 32'(busy_n), 32'(FRAME));
    check("single_pop_count", 32'(rd_cyc_q.size() - n0), 32'd1);

    // Two queued bytes go back-to-back.
    n0 = rd_cyc_q.size();
    nb = start_cyc_q.size();
    sync();
    push_byte(8'hA5);
    push_byte(8'h3C);
    wait_idle(400, 1'b1, busy_n);
    check("b2b_pop_count", 32'(rd_cyc_q.size() - n0), 32'd2);
    check("b2b_frame_count", 32'(start_cyc_q.size() - nb), 32'd2);
    if (rd_cyc_q.size() - n0 == 2)
      check("b2b_pop_spacing", 32'(rd_cyc_q[n0+1] - rd_cyc_q[n0]), 32'(FRAME));
    if (start_cyc_q.size() - nb == 2)
      check("b2b_start_spacing", 32'(start_cyc_q[nb+1] - start_cyc_q[nb]), 32'(FRAME));
    check("b2b_busy_cycles", 32'(busy_n), 32'(2 * FRAME));

    // Two stop bits.
    run_nstop2(8'hFF);
    run_nstop2(8'($urandom_range(0, 255)));

    // Reset during data bit 3.
    n0 = rd_cyc_q.size();
    sync();
    push_byte(8'h00);
    push_byte(8'h96);
    n = 0;
    while (rd_cyc_q.size() == n0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    check("rst_first_pop", 32'(rd_cyc_q.size() - n0), 32'd1);
    repeat (17) @(posedge clk);
    #1;
    check("rst_mid_frame_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_tx_immediate", 32'(tx), 32'd1);
    check("rst_busy_immediate", 32'(busy), 32'd0);
    check("rst_rd_held", 32'(rd), 32'd0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("rst_release_pop", 32'(rd), 32'd1);
    wait_idle(400, 1'b1, busy_n);
    check("rst_pop_count", 32'(rd_cyc_q.size() - n0), 32'd2);

`ifdef FIFOTX_CTS_EN
    sync();
    cts_n = 1'b1;
    repeat (3) @(posedge clk);
    n0 = rd_cyc_q.size();
    sync();
    push_byte(8'h5A);
    push_byte(8'hC3);
    repeat (20) @(posedge clk);
    check("cts_blocked_pops", 32'(rd_cyc_q.size() - n0), 32'd0);
    check("cts_blocked_busy", 32'(busy), 32'd0);
    sync();
    cts_n = 1'b0;
    @(posedge clk);
    #2;
    check("cts_latency_1", 32'(rd), 32'd0);
    @(posedge clk);
    #2;
    check("cts_latency_2", 32'(rd), 32'd1);
    repeat (10) @(posedge clk);
    #2 cts_n = 1'b1;
    wait_idle(400, 1'b0, busy_n);
    check("cts_mid_frame_pops", 32'(rd_cyc_q.size() - n0), 32'd1);
    check("cts_fifo_left", 32'(fifo_q.size()), 32'd1);
    repeat (10) @(posedge clk);
    check("cts_no_late_pop", 32'(rd_cyc_q.size() - n0), 32'd1);
    sync();
    cts_n = 1'b0;
    wait_idle(400, 1'b1, busy_n);
`endif

    // Randomized bursts with random gaps.
    for (int it = 0; it < 25; it++) begin
      sync();
      nb = $urandom_range(1, 3);
      for (int j = 0; j < nb; j++) push_byte(8'($urandom_range(0, 255)));
      if ($urandom_range(0, 1) == 1) wait_idle(1000, 1'b1, busy_n);
      else repeat ($urandom_range(0, 60)) @(posedge clk);
    end
    wait_idle(2000, 1'b1, busy_n);
    repeat (3) @(negedge clk);
    check("end_exp_queue_empty", 32'(exp_q.size()), 32'd0);
    check("end_fifo_empty", 32'(fifo_q.size()), 32'd0);
    check("end_line_idle", 32'(tx), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
